digit_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 15 +
 rtl/scan_prescaler.sv | 28 ++
 rtl/digit_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_digit_scan_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan path (scan controller and
// the digit-to-segment decoder downstream of it).
package seg_pkg;

  localparam int DIGIT_W = 4;

  // Any code above 9 is rendered as a dash by the decoder; this is the canonical one.
  localparam logic [DIGIT_W-1:0] DASH_CODE = 4'hF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot timer: count 0 is the BLANK cycle of a slot and count
// PRESCALE-1 is its final DRIVE cycle.
module scan_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_start_o,
  output logic slot_last_o
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign slot_start_o = (cnt_q == '0);
  assign slot_last_o  = (cnt_q == CNT_LAST);
  assign cnt_d        = slot_last_o ? '0 : cnt_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed N-digit scan controller with frame-boundary commit of new frames.
// Optional `LEADING_ZERO_BLANK_EN keeps anodes dark for leading-zero digits (slot 0 always lit).
module digit_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  input  logic [DIGIT_W*N_DIGITS-1:0]   load_data,
  output logic                          load_ready,
  output logic [DIGIT_W-1:0]            digit,
  output logic [N_DIGITS-1:0]           an_n,
  output logic [$clog2(N_DIGITS)-1:0]   slot_idx
);

  localparam int SLOT_W  = $clog2(N_DIGITS);
  localparam int FRAME_W = DIGIT_W * N_DIGITS;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_DIGITS - 1);

  scan_state_e          state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [FRAME_W-1:0]   display_q, display_d;
  logic [FRAME_W-1:0]   pending_q, pending_d;
  logic                 pend_q, pend_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic [N_DIGITS-1:0]  an_n_q, an_n_d;

  logic slot_start;
  logic slot_last;
  logic slot_end;
  logic frame_wrap;
  logic accept;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk          (clk),
    .rst_n        (rst_n),
    .slot_start_o (slot_start),
    .slot_last_o  (slot_last)
  );

  assign slot_end   = (state_q == DRIVE) && slot_last;
  assign frame_wrap = slot_end && (slot_q == SLOT_LAST);
  assign accept     = load_valid && load_ready;

  // State register (display/pending are reset too: the first frame must show zeros)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      slot_q    <= '0;
      display_q <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      digit_q   <= '0;
      an_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      display_q <= display_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      digit_q   <= digit_d;
      an_n_q    <= an_n_d;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BLANK: if (slot_start) state_d = DRIVE;
      DRIVE: if (slot_last)  state_d = BLANK;
    endcase
  end

  // Slot index, handshake and frame commit; transfer and commit are exclusive via load_ready
  always_comb begin
    slot_d    = slot_q;
    display_d = display_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    if (slot_end) slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    if (accept) begin
      pending_d = load_data;
      pend_d    = 1'b1;
    end
    if (frame_wrap && pend_q) begin
      display_d = pending_q;
      pend_d    = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead_zero;
`endif

  // Outputs are registered for the cycle being entered: the digit changes on entry to
  // BLANK, while the anode is dark, and the anode lights only on entry to DRIVE.
  always_comb begin
    digit_d = digit_q;
    an_n_d  = '1;
    if (state_d == BLANK) begin
      digit_d = display_d[int'(slot_d)*DIGIT_W +: DIGIT_W];
    end else begin
      an_n_d = ~(N_DIGITS'(1) << slot_q);
`ifdef LEADING_ZERO_BLANK_EN
      lead_zero = 1'b1;
      for (int k = 0; k < N_DIGITS; k++) begin
        if (k >= int'(slot_q) && display_q[k*DIGIT_W +: DIGIT_W] != '0) lead_zero = 1'b0;
      end
      if (slot_q != '0 && lead_zero) an_n_d = '1;
`endif
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (state_d == BLANK) lead_zero = 1'b0;
`endif
  end

  assign load_ready = ~pend_q;
  assign digit      = digit_q;
  assign an_n       = an_n_q;
  assign slot_idx   = slot_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with N_DIGITS=4, PRESCALE=4; honours `LEADING_ZERO_BLANK_EN.
module tb_digit_scan_ctrl;
  import seg_pkg::*;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  digit;
  logic [3:0]  an_n;
  logic [1:0]  slot_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  digit_scan_ctrl #(.N_DIGITS(4), .PRESCALE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .digit      (digit),
    .an_n       (an_n),
    .slot_idx   (slot_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        vld;
    logic [15:0] data;
    logic [3:0]  an_n;
    logic [1:0]  slot;
    logic [3:0]  digit;
    logic        rdy;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic advance_to(input int phase);
    while (cyc % 16 != phase) tick();
  endtask

  // Expected DRIVE anode pattern for slot k of frame f
  function automatic logic [3:0] exp_an(input logic [15:0] f, input int k);
    logic [3:0] m;
    m = ~(4'b0001 << k);
    if (LZB && k != 0 && (f >> (4 * k)) == 16'h0) m = 4'hF;
    return m;
  endfunction

  // Checks one whole frame; must be called on a slot-0 BLANK cycle
  task automatic check_frame(input string name, input logic [15:0] f);
    logic [3:0] d;
    check({name, "_aligned"}, cyc % 16, 0);
    for (int k = 0; k < 4; k++) begin
      d = f[4*k +: 4];
      check($sformatf("%s_s%0d_blank_an", name, k), an_n, 4'hF);
      check($sformatf("%s_s%0d_blank_digit", name, k), digit, d);
      check($sformatf("%s_s%0d_slot", name, k), slot_idx, k);
      tick();
      for (int p = 1; p < 4; p++) begin
        check($sformatf("%s_s%0d_p%0d_an", name, k, p), an_n, exp_an(f, k));
        check($sformatf("%s_s%0d_p%0d_digit", name, k, p), digit, d);
        tick();
      end
    end
  endtask

  task automatic load_one(input logic [15:0] f);
    check("load_ready_before_load", load_ready, 1'b1);
    load_valid = 1'b1;
    load_data  = f;
    tick();
    load_valid = 1'b0;
    check("load_ready_after_accept", load_ready, 1'b0);
  endtask

  initial begin
    logic [3:0] z1, z2, z3;
    z1 = LZB ? 4'hF : 4'hD;
    z2 = LZB ? 4'hF : 4'hB;
    z3 = LZB ? 4'hF : 4'h7;

    //           cyc vld data      an_n   slot  digit rdy
    vecs[0]  = '{0,  0, 16'h0,    4'hF,  2'd0, 4'h0, 1'b1};
    vecs[1]  = '{1,  0, 16'h0,    4'hE,  2'd0, 4'h0, 1'b1};
    vecs[2]  = '{3,  0, 16'h0,    4'hE,  2'd0, 4'h0, 1'b1};
    vecs[3]  = '{4,  0, 16'h0,    4'hF,  2'd1, 4'h0, 1'b1};
    vecs[4]  = '{5,  0, 16'h0,    z1,    2'd1, 4'h0, 1'b1};
    vecs[5]  = '{8,  0, 16'h0,    4'hF,  2'd2, 4'h0, 1'b1};
    vecs[6]  = '{9,  0, 16'h0,    z2,    2'd2, 4'h0, 1'b1};
    vecs[7]  = '{13, 0, 16'h0,    z3,    2'd3, 4'h0, 1'b1};
    vecs[8]  = '{15, 0, 16'h0,    z3,    2'd3, 4'h0, 1'b1};
    vecs[9]  = '{16, 0, 16'h0,    4'hF,  2'd0, 4'h0, 1'b1};
    vecs[10] = '{17, 0, 16'h0,    4'hE,  2'd0, 4'h0, 1'b1};
    vecs[11] = '{22, 1, 16'h4321, z1,    2'd1, 4'h0, 1'b1};
    vecs[12] = '{23, 0, 16'h0,    z1,    2'd1, 4'h0, 1'b0};
    vecs[13] = '{31, 0, 16'h0,    z3,    2'd3, 4'h0, 1'b0};
    vecs[14] = '{32, 0, 16'h0,    4'hF,  2'd0, 4'h1, 1'b1};
    vecs[15] = '{33, 0, 16'h0,    4'hE,  2'd0, 4'h1, 1'b1};
    vecs[16] = '{36, 0, 16'h0,    4'hF,  2'd1, 4'h2, 1'b1};
    vecs[17] = '{41, 0, 16'h0,    4'hB,  2'd2, 4'h3, 1'b1};
    vecs[18] = '{45, 0, 16'h0,    4'h7,  2'd3, 4'h4, 1'b1};

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an_n", an_n, 4'hF);
    check("rst_ready", load_ready, 1'b1);
    check("rst_digit", digit, 4'h0);
    check("rst_slot", slot_idx, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    // Reset scan and a single mid-frame load
    foreach (vecs[i]) begin
      while (cyc < vecs[i].cyc) tick();
      load_valid = vecs[i].vld;
      load_data  = vecs[i].data;
      check($sformatf("vec%0d_an_n", i), an_n, vecs[i].an_n);
      check($sformatf("vec%0d_slot", i), slot_idx, vecs[i].slot);
      check($sformatf("vec%0d_digit", i), digit, vecs[i].digit);
      check($sformatf("vec%0d_ready", i), load_ready, vecs[i].rdy);
      tick();
      load_valid = 1'b0;
    end

    // Out-of-range codes pass through unchanged
    advance_to(2);
    load_one({DASH_CODE, 12'h005});
    advance_to(0);
    check("inv_ready_after_commit", load_ready, 1'b1);
    check_frame("inv", {DASH_CODE, 12'h005});

    // Back-pressure: 9999 held while 4321 is pending
    advance_to(2);
    check("bp_ready_initial", load_ready, 1'b1);
    load_valid = 1'b1;
    load_data  = 16'h4321;
    tick();
    load_data  = 16'h9999;
    while (cyc % 16 != 0) begin
      check("bp_ready_held_low", load_ready, 1'b0);
      tick();
    end
    check("bp_ready_after_commit", load_ready, 1'b1);
    check_frame("bp_first", 16'h4321);
    load_valid = 1'b0;
    check("bp_ready_second_commit", load_ready, 1'b1);
    check_frame("bp_second", 16'h9999);

    // Leading zeros (anodes depend on build option)
    advance_to(2);
    load_one(16'h0070);
    advance_to(0);
    check_frame("lz0070", 16'h0070);
    advance_to(2);
    load_one(16'h0000);
    advance_to(0);
    check_frame("lz0000", 16'h0000);

    // Asynchronous reset during slot 2 DRIVE with a frame pending
    advance_to(2);
    load_one(16'hABCD);
    advance_to(10);
    check("mid_rst_pending", load_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_an_n", an_n, 4'hF);
    check("mid_rst_ready", load_ready, 1'b1);
    check("mid_rst_slot", slot_idx, 2'd0);
    check("mid_rst_digit", digit, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    check_frame("post_rst_a", 16'h0000);
    check_frame("post_rst_b", 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
